// File: rtl/bin2bcd_seq_wfs_pkg.sv
// Shared constants and state type for the sequential binary-to-BCD converter.
package bcd_pkg_wfs;

    localparam int unsigned BIN_W    = 14;
    localparam int unsigned N_DIGITS = 4;
    localparam int unsigned BCD_W    = 4 * N_DIGITS;
    localparam int unsigned SHR_W    = BCD_W + BIN_W;
    localparam int unsigned MAX_VAL  = (10 ** N_DIGITS) - 1;
    localparam int unsigned CNT_W    = $clog2(BIN_W + 1);

    // MAX_VAL at the width of the binary input, for the range comparison
    localparam logic [BIN_W-1:0] MAX_BIN = BIN_W'(MAX_VAL);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

endpackage

// File: rtl/bin2bcd_seq_wfs_if.sv
// Start/busy/done handshake and result bus of the binary-to-BCD converter.
interface bin2bcd_seq_wfs_if;
    import bcd_pkg_wfs::*;

    logic             start_wfs;
    logic [BIN_W-1:0] binary_wfs;
    logic             busy_wfs;
    logic             done_wfs;
    logic             range_err_wfs;
    logic [3:0]       thousands_wfs;
    logic [3:0]       hundreds_wfs;
    logic [3:0]       tens_wfs;
    logic [3:0]       ones_wfs;

    modport master (
        output start_wfs, binary_wfs,
        input  busy_wfs, done_wfs, range_err_wfs,
        input  thousands_wfs, hundreds_wfs, tens_wfs, ones_wfs
    );

    modport slave (
        input  start_wfs, binary_wfs,
        output busy_wfs, done_wfs, range_err_wfs,
        output thousands_wfs, hundreds_wfs, tens_wfs, ones_wfs
    );

endinterface

// File: rtl/bin2bcd_seq_wfs_add3.sv
// Double-dabble nibble corrector: adds 3 to any BCD nibble of 5 or more.
module bcd_add3_wfs (
    input  logic [3:0] i_nib,
    output logic [3:0] o_nib
);

    // Correct before the shift so the doubled nibble carries into the next digit
    always_comb begin
        o_nib = i_nib;
        if (i_nib >= 4'd5) begin
            o_nib = i_nib + 4'd3;
        end
    end

endmodule

// File: rtl/bin2bcd_seq_wfs.sv
// Sequential binary-to-BCD converter, one shift-add-3 step per clock.
module bin2bcd_seq_wfs
    import bcd_pkg_wfs::*;
(
    input  logic              clk_wfs,
    input  logic              rst_n_wfs,
    bin2bcd_seq_wfs_if.slave  bus
);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [SHR_W-1:0]   r_shr;
    logic               r_rng;
    logic               r_busy;
    logic               r_done;
    logic               r_rng_out;
    logic [BCD_W-1:0]   r_digits;
    logic [BCD_W-1:0]   w_adj;

    // One corrector per BCD digit of the shifter
    for (genvar g = 0; g < N_DIGITS; g++) begin : g_add3
        bcd_add3_wfs u_add3 (
            .i_nib (r_shr[BIN_W + 4*g +: 4]),
            .o_nib (w_adj[4*g +: 4])
        );
    end

    // Control FSM, shifter and registered outputs
    always_ff @(posedge clk_wfs or negedge rst_n_wfs) begin
        if (!rst_n_wfs) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_shr     <= '0;
            r_rng     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_rng_out <= 1'b0;
            r_digits  <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start_wfs) begin
                        r_shr   <= {{BCD_W{1'b0}}, bus.binary_wfs};
                        r_cnt   <= '0;
                        r_rng   <= (bus.binary_wfs > MAX_BIN);
                        r_busy  <= 1'b1;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Top bit of the corrected field falls off the end (overflow discarded)
                    r_shr <= {w_adj, r_shr[BIN_W-1:0]} << 1;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(BIN_W - 1)) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_digits  <= r_rng ? '0 : r_shr[SHR_W-1 -: BCD_W];
                    r_rng_out <= r_rng;
                    r_done    <= 1'b1;
                    r_busy    <= 1'b0;
                    r_state   <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy_wfs      = r_busy;
    assign bus.done_wfs      = r_done;
    assign bus.range_err_wfs = r_rng_out;
    assign bus.thousands_wfs = r_digits[15:12];
    assign bus.hundreds_wfs  = r_digits[11:8];
    assign bus.tens_wfs      = r_digits[7:4];
    assign bus.ones_wfs      = r_digits[3:0];

endmodule

// File: tb/tb_bin2bcd_seq_wfs.sv
// Scoreboard bench for bin2bcd_seq_wfs: stimulus pushes expectations, a monitor pops them on done.
module tb_bin2bcd_seq_wfs;

    typedef struct {
        int unsigned val;
        logic [16:0] exp;   // {range_err, thousands, hundreds, tens, ones}
    } exp_t;

    logic clk_wfs;
    logic rst_n_wfs;
    bin2bcd_seq_wfs_if bus ();

    exp_t sb[$];
    int   n_vec;
    int   n_err;
    int   n_done;

    bin2bcd_seq_wfs dut (
        .clk_wfs   (clk_wfs),
        .rst_n_wfs (rst_n_wfs),
        .bus       (bus)
    );

    initial clk_wfs = 1'b0;
    always #5 clk_wfs = ~clk_wfs;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic logic [16:0] ref_bcd(input int unsigned v);
        logic [3:0] th, hu, te, on;
        th = 4'(v / 1000);
        hu = 4'((v / 100) % 10);
        te = 4'((v / 10) % 10);
        on = 4'(v % 10);
        return {1'b0, th, hu, te, on};
    endfunction

    // Monitor: every done pulse consumes one scoreboard entry
    always @(negedge clk_wfs) begin
        if (rst_n_wfs && bus.done_wfs) begin
            exp_t e;
            n_done++;
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL spurious_done: got done with empty scoreboard, expected none");
            end else begin
                e = sb.pop_front();
                check("digits", {16'h0, bus.thousands_wfs, bus.hundreds_wfs, bus.tens_wfs, bus.ones_wfs},
                      {16'h0, e.exp[15:0]});
                check("range_err", {31'h0, bus.range_err_wfs}, {31'h0, e.exp[16]});
                if (!e.exp[16]) begin
                    check("roundtrip",
                          32'(int'(bus.thousands_wfs) * 1000 + int'(bus.hundreds_wfs) * 100 +
                              int'(bus.tens_wfs) * 10 + int'(bus.ones_wfs)),
                          32'(e.val));
                end
            end
        end
    end

    // Issue one conversion from a negedge with the DUT in IDLE; returns at the done negedge.
    // glitch > 0 re-pulses start (binary 777) at that many cycles after acceptance.
    task automatic do_conv(input int unsigned v, input logic [16:0] exp, input int glitch);
        exp_t e;
        int   lat;
        int   bc;
        e.val = v;
        e.exp = exp;
        sb.push_back(e);
        bus.start_wfs  = 1'b1;
        bus.binary_wfs = 14'(v);
        @(negedge clk_wfs);
        bus.start_wfs  = 1'b0;
        bus.binary_wfs = 14'($urandom);
        lat = 0;
        bc  = 0;
        while (!bus.done_wfs && lat < 40) begin
            if (bus.busy_wfs) bc++;
            if (glitch > 0 && lat == glitch - 1) begin
                bus.start_wfs  = 1'b1;
                bus.binary_wfs = 14'd777;
            end else begin
                bus.start_wfs  = 1'b0;
            end
            @(negedge clk_wfs);
            lat++;
        end
        bus.start_wfs = 1'b0;
        check("latency", 32'(lat), 32'd15);
        check("busy_cycles", 32'(bc), 32'd15);
        check("busy_low_at_done", {31'h0, bus.busy_wfs}, 32'h0);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        n_vec = 0;
        n_err = 0;
        n_done = 0;
        bus.start_wfs  = 1'b0;
        bus.binary_wfs = '0;
        rst_n_wfs = 1'b1;
        #3 rst_n_wfs = 1'b0;
        repeat (2) @(negedge clk_wfs);
        check("reset_busy", {31'h0, bus.busy_wfs}, 32'h0);
        check("reset_done", {31'h0, bus.done_wfs}, 32'h0);
        check("reset_rng", {31'h0, bus.range_err_wfs}, 32'h0);
        check("reset_digits", {16'h0, bus.thousands_wfs, bus.hundreds_wfs, bus.tens_wfs, bus.ones_wfs}, 32'h0);
        rst_n_wfs = 1'b1;
        @(negedge clk_wfs);

        // Directed vectors
        do_conv(0,     17'h0_0000, 0);
        do_conv(1234,  17'h0_1234, 0);
        do_conv(9999,  17'h0_9999, 0);
        do_conv(5,     17'h0_0005, 0);
        do_conv(10000, 17'h1_0000, 0);
        repeat (3) @(negedge clk_wfs);
        check("rng_held", {31'h0, bus.range_err_wfs}, 32'h1);
        check("rng_digits_zero", {16'h0, bus.thousands_wfs, bus.hundreds_wfs, bus.tens_wfs, bus.ones_wfs}, 32'h0);
        do_conv(42,    17'h0_0042, 0);
        repeat (2) @(negedge clk_wfs);
        check("digits_held", {16'h0, bus.thousands_wfs, bus.hundreds_wfs, bus.tens_wfs, bus.ones_wfs}, 32'h0042);

        // Start re-pulsed mid-conversion must be ignored
        d0 = n_done;
        do_conv(1234, 17'h0_1234, 3);
        repeat (20) @(negedge clk_wfs);
        check("single_done", 32'(n_done - d0), 32'd1);

        // Asynchronous reset in the middle of a conversion
        begin
            exp_t e;
            e.val = 1234;
            e.exp = 17'h0_1234;
            sb.push_back(e);
            bus.start_wfs  = 1'b1;
            bus.binary_wfs = 14'd1234;
            @(negedge clk_wfs);
            bus.start_wfs = 1'b0;
            repeat (6) @(negedge clk_wfs);
            rst_n_wfs = 1'b0;
            #1;
            check("midrst_busy", {31'h0, bus.busy_wfs}, 32'h0);
            check("midrst_done", {31'h0, bus.done_wfs}, 32'h0);
            check("midrst_digits", {16'h0, bus.thousands_wfs, bus.hundreds_wfs, bus.tens_wfs, bus.ones_wfs}, 32'h0);
            sb.delete();
            repeat (2) @(negedge clk_wfs);
            rst_n_wfs = 1'b1;
            @(negedge clk_wfs);
        end
        do_conv(2024, 17'h0_2024, 0);

        // Back-to-back sweep: dense near zero, strided across the full range
        for (int unsigned v = 0; v < 10000; v += (v < 200) ? 1 : 37) begin
            do_conv(v, ref_bcd(v), 0);
        end
        do_conv(9998, 17'h0_9998, 0);

        repeat (20) @(negedge clk_wfs);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bin2bcd_seq_wfs.md
# bin2bcd_seq_wfs

Sequential binary-to-BCD converter using the double-dabble (shift-add-3) algorithm, one bit per clock. Takes a 14-bit unsigned binary value and produces four packed BCD digits (thousands to ones) for the seven-segment display path. It is the reverse of the combinational BCD-to-binary decoder in the lab1 datapath. Start/busy/done handshake, one conversion in flight.

## Interface
- BIN_W, 14, width of binary input; also the number of shift cycles
- N_DIGITS, 4, BCD digits produced; MAX_VAL = 10^N_DIGITS − 1 (9999)

- clk_wfs  input  1  clock, rising edge
- rst_n_wfs  input  1  asynchronous, active-low reset
- start_wfs  input  1  request; sampled only in IDLE
- binary_wfs  input  BIN_W  unsigned value; captured on accepted start
- busy_wfs  output  1  high in SHIFT and DONE
- done_wfs  output  1  one-cycle pulse, results valid
- range_err_wfs  output  1  captured value > MAX_VAL; held with results
- thousands_wfs  output  4  BCD digit 3
- hundreds_wfs  output  4  BCD digit 2
- tens_wfs  output  4  BCD digit 1
- ones_wfs  output  4  BCD digit 0

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE: start_wfs=1 at an edge → load shifter {16'b0, binary_wfs}, bit counter=0, latch range_err = (binary_wfs > MAX_VAL), go SHIFT. start_wfs=0 → stay IDLE.
- SHIFT, each cycle: every BCD nibble ≥ 5 gets +3, then the full shifter is shifted left by 1. Counter increments; after the BIN_W-th shift → DONE.
- DONE: output registers load from the shifter BCD field. If range_err, all four digit outputs load 0. done_wfs=1 for this cycle only; next edge → IDLE.
- Digit outputs and range_err_wfs hold their values until the next DONE or reset.
- start_wfs in SHIFT or DONE: ignored, no queuing. binary_wfs changes after capture: ignored.
- Overflow bits shifted beyond the top nibble are discarded. Correctness is required only for inputs ≤ MAX_VAL.
- Reset (async assert, any state): state=IDLE, counter=0, shifter=0. All outputs 0: busy, done, range_err, all digits.
- Reset deassertion is synchronised externally. The block requires no start on the first edge after release.

## Timing
- Accepted start at edge k. busy_wfs high from after edge k through edge k+15. SHIFT occupies edges k+1..k+14. done_wfs high in the cycle after edge k+15.
- Latency from start edge to done: 15 cycles. Digits valid in the same cycle as done.
- Throughput: one conversion per 16 cycles; the earliest next start is the edge that leaves DONE+1 (IDLE).
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Package bcd_pkg_wfs:
  - constants BIN_W, N_DIGITS, BCD_W (=4·N_DIGITS), MAX_VAL
  - state typedef {IDLE, SHIFT, DONE}
  - counter width $clog2(BIN_W+1)
- Sub-module bcd_add3_wfs: combinational nibble corrector (in ≥ 5 → in+3, else in). Instantiated N_DIGITS times on the shifter BCD field.
- Top: FSM, counter, shifter register, output registers.

## Test plan
- Reset, then start with binary=0 → done at start+15, digits 0/0/0/0, range_err=0, busy high exactly 15 cycles.
- binary=1234 → digits 1/2/3/4. binary=9999 → 9/9/9/9. binary=5 → 0/0/0/5 (the add-3 boundary).
- binary=10000 → range_err=1, digits 0/0/0/0. A following conversion of 42 → range_err=0, digits 0/0/4/2.
- start pulsed at start+3 with binary=777 during a 1234 conversion → result still 1/2/3/4, exactly one done pulse.
- rst_n_wfs asserted at start+7 → busy, done and digits read 0 immediately. After release, a new conversion of 2024 → 2/0/2/4.
- Exhaustive sweep 0..9999, back-to-back starts issued in IDLE → every result equals the decimal digits. Each conversion feeds the BCD-to-binary decoder and round-trips to the original value.
